// File: rtl/key_gesture_if.sv
// Key gesture bundle: the debounced key level in, gesture pulses and busy out.
interface key_gesture_if;
   logic key_b;
   logic click;
   logic dbl_click;
   logic long_press;
   logic rpt;
   logic busy;

   modport master (output key_b, input click, dbl_click, long_press, rpt, busy);
   modport slave  (input key_b, output click, dbl_click, long_press, rpt, busy);
endinterface

// File: rtl/key_gesture.sv
// Click / double-click / long-press / auto-repeat classifier for one key.
// All state moves on the falling edge of clk_sys.
module key_gesture #(
   parameter int bitwidth = 24,
   parameter int longT    = 5000000,
   parameter int dblT     = 2500000,
   parameter int repT     = 1250000
) (
   input  logic           clk_sys,
   input  logic           rst_n,
   key_gesture_if.slave   kif
);
   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] PRESS1 = 3'd1;
   localparam logic [2:0] WAIT2  = 3'd2;
   localparam logic [2:0] PRESS2 = 3'd3;
   localparam logic [2:0] LONG   = 3'd4;

   localparam logic [bitwidth-1:0] LONG_LAST = bitwidth'(longT - 1);
   localparam logic [bitwidth-1:0] DBL_LAST  = bitwidth'(dblT - 1);
   localparam logic [bitwidth-1:0] REP_LAST  = bitwidth'(repT - 1);

   logic [1:0]          sync;
   logic [2:0]          state;
   logic [bitwidth-1:0] cnt;
   logic                click_q, dbl_q, long_q, rpt_q;
   logic                pressed;

   assign pressed = ~sync[1];

   always_ff @(negedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         sync    <= 2'b11;
         state   <= IDLE;
         cnt     <= '0;
         click_q <= 1'b0;
         dbl_q   <= 1'b0;
         long_q  <= 1'b0;
         rpt_q   <= 1'b0;
      end else begin
         sync    <= {sync[0], kif.key_b};
         click_q <= 1'b0;
         dbl_q   <= 1'b0;
         long_q  <= 1'b0;
         rpt_q   <= 1'b0;
         case (state)
            IDLE: begin
               if (pressed) begin
                  state <= PRESS1;
                  cnt   <= '0;
               end
            end
            // release is tested first so it wins over the long threshold
            PRESS1: begin
               if (!pressed) begin
                  state <= WAIT2;
                  cnt   <= '0;
               end else if (cnt == LONG_LAST) begin
                  state  <= LONG;
                  cnt    <= '0;
                  long_q <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            // press is tested first so it wins over the window expiry
            WAIT2: begin
               if (pressed) begin
                  state <= PRESS2;
                  cnt   <= '0;
                  dbl_q <= 1'b1;
               end else if (cnt == DBL_LAST) begin
                  state   <= IDLE;
                  cnt     <= '0;
                  click_q <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            PRESS2: begin
               if (!pressed) begin
                  state <= IDLE;
                  cnt   <= '0;
               end
            end
            LONG: begin
               if (!pressed) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if (cnt == REP_LAST) begin
                  cnt   <= '0;
                  rpt_q <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   assign kif.click      = click_q;
   assign kif.dbl_click  = dbl_q;
   assign kif.long_press = long_q;
   assign kif.rpt        = rpt_q;
   assign kif.busy       = (state != IDLE);
endmodule

// File: tb/tb_key_gesture.sv
// Directed checks of key_gesture with short timing constants (8/6/4).
// A key change driven just after rising edge k is acted on by the FSM at falling edge k+2.
module tb_key_gesture;
   logic clk_sys;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   key_gesture_if kif ();

   key_gesture #(.bitwidth(24), .longT(8), .dblT(6), .repT(4)) dut (
      .clk_sys (clk_sys),
      .rst_n   (rst_n),
      .kif     (kif)
   );

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   // pulse monitor, sampled on the rising edge (outputs move on the falling edge)
   int cyc = 0;
   int n_click, n_dbl, n_long, n_rpt;
   int t_click, t_dbl, t_long, t_rpt0, t_rpt;
   always @(posedge clk_sys) begin
      cyc = cyc + 1;
      if (kif.click)      begin n_click++; t_click = cyc; end
      if (kif.dbl_click)  begin n_dbl++;   t_dbl   = cyc; end
      if (kif.long_press) begin n_long++;  t_long  = cyc; end
      if (kif.rpt) begin
         if (n_rpt == 0) t_rpt0 = cyc;
         n_rpt++;
         t_rpt = cyc;
      end
   end

   task automatic clear();
      n_click = 0; n_dbl = 0; n_long = 0; n_rpt = 0;
      t_click = -1; t_dbl = -1; t_long = -1; t_rpt0 = -1; t_rpt = -1;
   endtask

   task automatic hold(input int n);
      repeat (n) @(posedge clk_sys);
      #1;
   endtask

   task automatic test_reset();
      logic [4:0] o;
      #1;
      o = {kif.click, kif.dbl_click, kif.long_press, kif.rpt, kif.busy};
      checks++;
      if (o !== 5'b0) begin errors++; $display("FAIL reset_outputs: got %b want 00000", o); end
      kif.key_b = 1'b0;
      hold(4);
      checks++;
      if (kif.busy !== 1'b0) begin errors++; $display("FAIL reset_hold_busy: got %b want 0", kif.busy); end
      kif.key_b = 1'b1;
      hold(3);
      rst_n = 1'b1;
      hold(4);
      checks++;
      if (kif.busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy: got %b want 0", kif.busy); end
   endtask

   task automatic test_click();
      int k;
      clear(); k = cyc;
      kif.key_b = 1'b0; hold(3);
      checks++;
      if (kif.busy !== 1'b1) begin errors++; $display("FAIL click_busy_pressed: got %b want 1", kif.busy); end
      kif.key_b = 1'b1; hold(14);
      checks++;
      if (n_click != 1 || t_click != k + 12)
         begin errors++; $display("FAIL click_pulse: got n=%0d at %0d want n=1 at %0d", n_click, t_click, k + 12); end
      checks++;
      if (n_dbl + n_long + n_rpt != 0) begin errors++; $display("FAIL click_other_pulses: got %0d want 0", n_dbl + n_long + n_rpt); end
      checks++;
      if (kif.busy !== 1'b0) begin errors++; $display("FAIL click_busy_after: got %b want 0", kif.busy); end
   endtask

   task automatic test_dbl_click();
      int k;
      clear(); k = cyc;
      kif.key_b = 1'b0; hold(3);
      kif.key_b = 1'b1; hold(2);
      kif.key_b = 1'b0; hold(3);
      kif.key_b = 1'b1; hold(14);
      checks++;
      if (n_dbl != 1 || t_dbl != k + 8)
         begin errors++; $display("FAIL dbl_pulse: got n=%0d at %0d want n=1 at %0d", n_dbl, t_dbl, k + 8); end
      checks++;
      if (n_click != 0) begin errors++; $display("FAIL dbl_no_click: got %0d want 0", n_click); end
      checks++;
      if (kif.busy !== 1'b0) begin errors++; $display("FAIL dbl_busy_after: got %b want 0", kif.busy); end
   endtask

   // press lands exactly as the double-click window expires: press wins
   task automatic test_dbl_edge();
      int k;
      clear(); k = cyc;
      kif.key_b = 1'b0; hold(3);
      kif.key_b = 1'b1; hold(6);
      kif.key_b = 1'b0; hold(3);
      kif.key_b = 1'b1; hold(14);
      checks++;
      if (n_dbl != 1 || t_dbl != k + 12 || n_click != 0)
         begin errors++; $display("FAIL dbl_edge: got dbl=%0d at %0d click=%0d want dbl=1 at %0d click=0", n_dbl, t_dbl, n_click, k + 12); end
   endtask

   task automatic test_triple();
      int k;
      clear(); k = cyc;
      kif.key_b = 1'b0; hold(3);
      kif.key_b = 1'b1; hold(2);
      kif.key_b = 1'b0; hold(3);
      kif.key_b = 1'b1; hold(2);
      kif.key_b = 1'b0; hold(3);
      kif.key_b = 1'b1; hold(14);
      checks++;
      if (n_dbl != 1 || t_dbl != k + 8)
         begin errors++; $display("FAIL triple_dbl: got n=%0d at %0d want n=1 at %0d", n_dbl, t_dbl, k + 8); end
      checks++;
      if (n_click != 1 || t_click != k + 22)
         begin errors++; $display("FAIL triple_click: got n=%0d at %0d want n=1 at %0d", n_click, t_click, k + 22); end
   endtask

   task automatic test_long();
      int k;
      clear(); k = cyc;
      kif.key_b = 1'b0; hold(20);
      checks++;
      if (n_long != 1 || t_long != k + 11)
         begin errors++; $display("FAIL long_pulse: got n=%0d at %0d want n=1 at %0d", n_long, t_long, k + 11); end
      checks++;
      if (n_rpt != 2 || t_rpt0 != k + 15 || t_rpt != k + 19)
         begin errors++; $display("FAIL long_repeat: got n=%0d first %0d last %0d want n=2 first %0d last %0d", n_rpt, t_rpt0, t_rpt, k + 15, k + 19); end
      kif.key_b = 1'b1; hold(10);
      checks++;
      if (n_click != 0 || n_dbl != 0 || n_rpt != 2)
         begin errors++; $display("FAIL long_release: got click=%0d dbl=%0d rpt=%0d want 0 0 2", n_click, n_dbl, n_rpt); end
      checks++;
      if (kif.busy !== 1'b0) begin errors++; $display("FAIL long_busy_after: got %b want 0", kif.busy); end
   endtask

   // release seen in the same cycle cnt reaches longT-1: release wins
   task automatic test_release_at_long();
      int k;
      clear(); k = cyc;
      kif.key_b = 1'b0; hold(8);
      kif.key_b = 1'b1; hold(12);
      checks++;
      if (n_long != 0) begin errors++; $display("FAIL rel_at_long_no_long: got %0d want 0", n_long); end
      checks++;
      if (n_click != 1 || t_click != k + 17)
         begin errors++; $display("FAIL rel_at_long_click: got n=%0d at %0d want n=1 at %0d", n_click, t_click, k + 17); end
   endtask

   task automatic test_reset_mid();
      logic [4:0] o;
      clear();
      kif.key_b = 1'b0; hold(3);
      kif.key_b = 1'b1; hold(4);
      checks++;
      if (kif.busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy_wait2: got %b want 1", kif.busy); end
      rst_n = 1'b0; #1;
      o = {kif.click, kif.dbl_click, kif.long_press, kif.rpt, kif.busy};
      checks++;
      if (o !== 5'b0) begin errors++; $display("FAIL rst_mid_async: got %b want 00000", o); end
      hold(3);
      rst_n = 1'b1; hold(12);
      checks++;
      if (n_click + n_dbl + n_long + n_rpt != 0 || kif.busy !== 1'b0)
         begin errors++; $display("FAIL rst_mid_after: got pulses=%0d busy=%b want 0 0", n_click + n_dbl + n_long + n_rpt, kif.busy); end
   endtask

   task automatic test_reset_held();
      int j;
      kif.key_b = 1'b0; hold(5);
      rst_n = 1'b0; hold(2);
      clear();
      rst_n = 1'b1; j = cyc;
      hold(12);
      checks++;
      if (n_long != 1 || t_long != j + 11 || n_click != 0)
         begin errors++; $display("FAIL rst_held_new_press: got long=%0d at %0d click=%0d want long=1 at %0d click=0", n_long, t_long, n_click, j + 11); end
      kif.key_b = 1'b1; hold(10);
      checks++;
      if (kif.busy !== 1'b0 || n_rpt != 0)
         begin errors++; $display("FAIL rst_held_release: got busy=%b rpt=%0d want 0 0", kif.busy, n_rpt); end
   endtask

   task automatic test_random();
      logic [3:0] p;
      for (int i = 0; i < 20000; i++) begin
         if ($urandom_range(0, 3) == 0) kif.key_b = ~kif.key_b;
         hold(1);
         p = {kif.click, kif.dbl_click, kif.long_press, kif.rpt};
         checks++;
         if ($countones(p) > 1) begin errors++; $display("FAIL rand_onehot: cycle %0d got %b want at most one set", cyc, p); end
         checks++;
         if (dut.cnt > 24'd7) begin errors++; $display("FAIL rand_cnt: cycle %0d got %0d want <= 7", cyc, dut.cnt); end
      end
      kif.key_b = 1'b1; hold(20);
   endtask

   initial begin
      rst_n = 1'b0;
      kif.key_b = 1'b1;
      clear();
      test_reset();
      test_click();
      test_dbl_click();
      test_dbl_edge();
      test_triple();
      test_long();
      test_release_at_long();
      test_reset_mid();
      test_reset_held();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
